dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Sequencer for the MEM stage of the pipelined core. It turns the decoded `MemRead`/`MemWrite` codes into a request/acknowledge transaction on a word-wide, variable-latency data memory, and freezes the pipeline until the access completes. It generates byte enables and lane-replicated store data, and sign- or zero-extends load data. Misaligned accesses and unanswered requests are reported as single-cycle exception pulses.

## Interface
Parameters:
- `TIMEOUT`, 64: bus cycles without `dm_ack_i` before a bus error; legal range 1..255.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `MEM_valid_i` in 1: MEM-stage instruction is valid (not flushed).
- `MEM_MemRead_i` in 3: load code. 000 none, 001 LW, 010 LH, 011 LHU, 100 LB, 101 LBU.
- `MEM_MemWrite_i` in 2: store code. 00 none, 01 SW, 10 SH, 11 SB.
- `MEM_addr_i` in 32: byte address (ALU result).
- `MEM_wdata_i` in 32: store data (rs2).
- `stall_o` out 1: freeze IF/ID/EX/MEM pipeline registers.
- `done_o` out 1: one-cycle pulse when an access completes.
- `rdata_o` out 32: extended load result.
- `misalign_o` out 1: one-cycle misaligned-access exception pulse.
- `buserr_o` out 1: one-cycle timeout exception pulse.
- `fault_addr_o` out 32: byte address of the last faulting access.
- `dm_req_o` out 1: memory request.
- `dm_we_o` out 1: request is a write.
- `dm_addr_o` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dm_be_o` out 4: byte enables.
- `dm_wdata_o` out 32: lane-replicated write data.
- `dm_ack_i` in 1: memory acknowledge. For reads, `dm_rdata_i` is valid in the same cycle.
- `dm_rdata_i` in 32: read word.

## Operation
- FSM states: IDLE, BUS, DONE, ERR. Reset puts the FSM in IDLE.
- Reset values: every output is 0 and the timeout counter is 0.
- IDLE, access present (`MEM_valid_i` high and either code nonzero):
  - `stall_o` is driven combinationally to 1 in this same cycle.
  - Alignment is checked: LW/SW require `addr[1:0]`=0; LH/LHU/SH require `addr[0]`=0; byte accesses are always aligned.
  - Aligned access: latch type, address, byte enables and write data, then go to BUS.
  - Misaligned access: latch `fault_addr_o`, go to ERR with `misalign_o` set. No `dm_req_o` is issued.
- IDLE, no access or `MEM_valid_i` low: stay in IDLE with all pulses at 0.
- Read and write codes both nonzero: the write is performed and the read is ignored.
- BUS:
  - `dm_req_o`=1 and all `dm_*` outputs are held stable from registers; `stall_o`=1.
  - The counter increments each cycle without an ack.
  - On `dm_ack_i`: capture the extended load into `rdata_o` (loads only), clear the counter, go to DONE.
  - Counter reaches `TIMEOUT` without an ack: drop `dm_req_o`, latch `fault_addr_o`, set `buserr_o`, go to ERR.
- DONE: `done_o`=1, `stall_o`=0. The pipeline advances at the end of this cycle. The next state is always IDLE, so the same instruction is never re-issued.
- ERR: the exception pulse is high, `stall_o`=0, the next state is IDLE.
- Store lane generation:
  - SB: `dm_be_o`=`1<<addr[1:0]`, `dm_wdata_o`=`{4{wdata[7:0]}}`.
  - SH: `dm_be_o`=`addr[1]`?1100:0011, `dm_wdata_o`=`{2{wdata[15:0]}}`.
  - SW: `dm_be_o`=1111, `dm_wdata_o`=`wdata`.
- Loads: `dm_we_o`=0, `dm_be_o` uses the same lane pattern as the access width, and `dm_wdata_o`=0.
- Load extraction:
  - Shift `dm_rdata_i` right by `8*addr[1:0]`.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- `rdata_o` holds its value across stores, errors and idle cycles. It changes only when a load completes.
- `dm_ack_i` outside BUS is ignored.

## Timing
- Minimum access (ack in the first BUS cycle) is 3 cycles: IDLE detect, BUS, DONE. `stall_o` is high for 2 cycles.
- An ack in the Nth BUS cycle gives `stall_o` high for N+1 cycles, followed by a 1-cycle DONE.
- Misaligned access: `stall_o` is high for 1 cycle, then `misalign_o` is high for 1 cycle.
- Timeout: `dm_req_o` is high for exactly `TIMEOUT` cycles; `buserr_o` pulses in the following cycle.
- `done_o`, `misalign_o` and `buserr_o` are mutually exclusive and never high for two consecutive cycles.
- Back-to-back accesses: the IDLE cycle after DONE/ERR evaluates the new MEM-stage instruction.
- `rst` asserted in any state: at the next edge the FSM returns to IDLE and all outputs and the counter are 0, including dropping a pending `dm_req_o`. A late ack is ignored.

## Test plan
- LW at 0x100, ack in the 3rd BUS cycle with 0xDEADBEEF:
  - `dm_addr_o`=0x100, `dm_be_o`=1111, `dm_req_o` high 3 cycles.
  - `stall_o` high 4 cycles, then `done_o` pulses with `rdata_o`=0xDEADBEEF.
- Loads with `dm_rdata_i`=0x80112233:
  - LB 0x103 gives 0xFFFFFF80; LBU 0x103 gives 0x00000080.
  - LH 0x102 gives 0xFFFF8011; LHU 0x102 gives 0x00008011.
  - LB 0x100 gives 0x00000033.
- SB at 0x201 with wdata 0x000000A5: `dm_addr_o`=0x200, `dm_we_o`=1, `dm_be_o`=0010, `dm_wdata_o`=0xA5A5A5A5. `rdata_o` is unchanged.
- SH at 0x203: `misalign_o` is a single pulse, `fault_addr_o`=0x203, `dm_req_o` never rises. A following LW at 0x204 completes normally.
- `TIMEOUT`=8 with no ack: `dm_req_o` high exactly 8 cycles, then `buserr_o` pulses once with `fault_addr_o` equal to the access address. Returns to IDLE.
- `rst` asserted in the 2nd BUS cycle: the next cycle has `dm_req_o`=0 and `stall_o`=0. An ack arriving one cycle later is ignored. A subsequent SW with prompt ack completes in 3 cycles.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer: turns load/store codes into a req/ack data-memory access and freezes the pipeline.
// Latency: 2 + ack-wait cycles; stall_o holds the pipeline until the access completes, errors or times out.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_valid_i,
    input  logic [2:0]  MEM_MemRead_i,
    input  logic [1:0]  MEM_MemWrite_i,
    input  logic [31:0] MEM_addr_i,
    input  logic [31:0] MEM_wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        buserr_o,
    output logic [31:0] fault_addr_o,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [31:0] dm_addr_o,
    output logic [3:0]  dm_be_o,
    output logic [31:0] dm_wdata_o,
    input  logic        dm_ack_i,
    input  logic [31:0] dm_rdata_i
);

    typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  ld_code;
    logic [31:0] addr_q;

    logic        access;
    logic        is_store;
    logic        aligned;
    logic [1:0]  size;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    // Access decode; a store code wins over a simultaneous load code.
    always_comb begin
        access    = MEM_valid_i && (MEM_MemRead_i != 3'b000 || MEM_MemWrite_i != 2'b00);
        is_store  = MEM_MemWrite_i != 2'b00;
        size      = 2'd2;
        aligned   = 1'b1;
        be_nxt    = 4'b1111;
        wdata_nxt = 32'h0;
        if (is_store) begin
            case (MEM_MemWrite_i)
                2'b01:   size = 2'd2;
                2'b10:   size = 2'd1;
                default: size = 2'd0;
            endcase
        end else begin
            case (MEM_MemRead_i)
                3'b010, 3'b011: size = 2'd1;
                3'b100, 3'b101: size = 2'd0;
                default:        size = 2'd2;
            endcase
        end
        case (size)
            2'd2: begin
                aligned = MEM_addr_i[1:0] == 2'b00;
                be_nxt  = 4'b1111;
                if (is_store) wdata_nxt = MEM_wdata_i;
            end
            2'd1: begin
                aligned = !MEM_addr_i[0];
                be_nxt  = MEM_addr_i[1] ? 4'b1100 : 4'b0011;
                if (is_store) wdata_nxt = {2{MEM_wdata_i[15:0]}};
            end
            default: begin
                aligned = 1'b1;
                be_nxt  = 4'b0001 << MEM_addr_i[1:0];
                if (is_store) wdata_nxt = {4{MEM_wdata_i[7:0]}};
            end
        endcase
    end

    always_comb begin
        shifted  = dm_rdata_i >> {addr_q[1:0], 3'b000};
        load_ext = shifted;
        case (ld_code)
            3'b010:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b011:  load_ext = {16'h0, shifted[15:0]};
            3'b100:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b101:  load_ext = {24'h0, shifted[7:0]};
            default: load_ext = shifted;
        endcase
    end

    // The detect cycle must stall before the FSM has registered anything.
    assign stall_o   = !rst && ((state == IDLE && access) || state == BUS);
    assign dm_addr_o = {addr_q[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 8'h0;
            ld_code      <= 3'b000;
            addr_q       <= 32'h0;
            done_o       <= 1'b0;
            rdata_o      <= 32'h0;
            misalign_o   <= 1'b0;
            buserr_o     <= 1'b0;
            fault_addr_o <= 32'h0;
            dm_req_o     <= 1'b0;
            dm_we_o      <= 1'b0;
            dm_be_o      <= 4'b0000;
            dm_wdata_o   <= 32'h0;
        end else begin
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
            buserr_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            state      <= BUS;
                            cnt        <= 8'h0;
                            dm_req_o   <= 1'b1;
                            dm_we_o    <= is_store;
                            addr_q     <= MEM_addr_i;
                            dm_be_o    <= be_nxt;
                            dm_wdata_o <= wdata_nxt;
                            ld_code    <= is_store ? 3'b000 : MEM_MemRead_i;
                        end else begin
                            state        <= ERR;
                            misalign_o   <= 1'b1;
                            fault_addr_o <= MEM_addr_i;
                        end
                    end
                end
                BUS: begin
                    if (dm_ack_i) begin
                        if (ld_code != 3'b000) rdata_o <= load_ext;
                        cnt      <= 8'h0;
                        dm_req_o <= 1'b0;
                        done_o   <= 1'b1;
                        state    <= DONE;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th unanswered request cycle.
                        cnt          <= 8'h0;
                        dm_req_o     <= 1'b0;
                        buserr_o     <= 1'b1;
                        fault_addr_o <= addr_q;
                        state        <= ERR;
                    end else begin
                        cnt <= cnt + 8'h1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed table, multi-cycle corner sequences and random accesses vs a reference model.
module tb_dmem_access_ctrl;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_valid;
    logic [2:0]  MEM_MemRead;
    logic [1:0]  MEM_MemWrite;
    logic [31:0] MEM_addr, MEM_wdata;
    logic        stall_o, done_o, misalign_o, buserr_o;
    logic [31:0] rdata_o, fault_addr_o;
    logic        dm_req_o, dm_we_o;
    logic [31:0] dm_addr_o, dm_wdata_o;
    logic [3:0]  dm_be_o;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    dmem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .MEM_valid_i(MEM_valid), .MEM_MemRead_i(MEM_MemRead),
        .MEM_MemWrite_i(MEM_MemWrite), .MEM_addr_i(MEM_addr), .MEM_wdata_i(MEM_wdata),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .misalign_o(misalign_o),
        .buserr_o(buserr_o), .fault_addr_o(fault_addr_o), .dm_req_o(dm_req_o), .dm_we_o(dm_we_o),
        .dm_addr_o(dm_addr_o), .dm_be_o(dm_be_o), .dm_wdata_o(dm_wdata_o),
        .dm_ack_i(dm_ack), .dm_rdata_i(dm_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int viol  = 0;
    logic [31:0] rd_model = 32'h0;

    typedef struct {
        logic [2:0]  rd;
        logic [1:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rword;
        int          lat;     // BUS cycle carrying the ack; 0 = never
        int          kind;    // 0 done, 1 misalign, 2 bus error
        logic [3:0]  be;
        logic [31:0] dwd;
        logic [31:0] res;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input int lat, input logic [31:0] rword,
                                input int kind, input logic [3:0] be, input logic [31:0] dwd,
                                input logic [31:0] res);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.lat = lat; v.rword = rword;
        v.kind = kind; v.be = be; v.dwd = dwd; v.res = res;
        return v;
    endfunction

    // Reference: access width in bytes drives alignment, lane mask, replication and extension.
    function automatic vec_t model(input vec_t v);
        int          width;
        int          off;
        int          mask;
        logic [31:0] sh;
        logic [31:0] b;
        logic        sgn;
        vec_t        r;
        r = v;
        if (v.wr != 2'd0) width = (v.wr == 2'd1) ? 4 : (v.wr == 2'd2) ? 2 : 1;
        else width = (v.rd == 3'd2 || v.rd == 3'd3) ? 2 : (v.rd == 3'd4 || v.rd == 3'd5) ? 1 : 4;
        off = int'(v.addr % 4);
        if (int'(v.addr % 4) % width != 0) r.kind = 1;
        else if (v.lat == 0 || v.lat > TO) r.kind = 2;
        else r.kind = 0;
        mask = (1 << width) - 1;
        r.be = 4'(mask << off);
        if (v.wr != 2'd0)
            r.dwd = (width == 4) ? v.wdata : (width == 2) ? (v.wdata % 65536) * 32'h0001_0001
                                                          : (v.wdata % 256) * 32'h0101_0101;
        else
            r.dwd = 32'h0;
        sh = v.rword >> (8 * off);
        if (width == 4) r.res = sh;
        else begin
            b   = sh % (32'd1 << (8 * width));
            sgn = (v.rd == 3'd2 || v.rd == 3'd4);
            if (sgn && b >= (32'd1 << (8 * width - 1))) b = b - (32'd1 << (8 * width));
            r.res = b;
        end
        return r;
    endfunction

    // Entered and left at posedge+1; presents one instruction and follows it to its completion pulse.
    task automatic run_vec(input vec_t v, input string tag);
        int          stall_n = 0, req_n = 0, dn = 0, ms = 0, be_n = 0, cyc = 0, got;
        logic        fin = 1'b0, unstable = 1'b0, we0 = 1'b0;
        logic [31:0] a0 = 32'h0, wd0 = 32'h0;
        logic [3:0]  b0 = 4'h0;
        MEM_valid = 1'b1; MEM_MemRead = v.rd; MEM_MemWrite = v.wr;
        MEM_addr = v.addr; MEM_wdata = v.wdata;
        while (!fin && cyc < 40) begin
            #1;
            cyc++;
            if (stall_o) stall_n++;
            dm_ack = 1'b0;
            dm_rdata = $urandom;
            if (dm_req_o) begin
                req_n++;
                if (req_n == 1) begin
                    a0 = dm_addr_o; b0 = dm_be_o; we0 = dm_we_o; wd0 = dm_wdata_o;
                end else if (a0 !== dm_addr_o || b0 !== dm_be_o || we0 !== dm_we_o || wd0 !== dm_wdata_o)
                    unstable = 1'b1;
                if (req_n == v.lat) begin
                    dm_ack = 1'b1;
                    dm_rdata = v.rword;
                end
            end
            if (done_o) dn++;
            if (misalign_o) ms++;
            if (buserr_o) be_n++;
            if (done_o || misalign_o || buserr_o) fin = 1'b1;
            @(posedge clk); #1;
        end
        dm_ack = 1'b0;
        chk({tag, "_completed"}, 32'(fin), 32'd1);
        got = (dn > 0) ? 0 : (ms > 0) ? 1 : (be_n > 0) ? 2 : 3;
        chk({tag, "_outcome"}, 32'(got), 32'(v.kind));
        chk({tag, "_stall_cycles"}, 32'(stall_n), 32'((v.kind == 0) ? v.lat + 1 : (v.kind == 1) ? 1 : TO + 1));
        chk({tag, "_req_cycles"}, 32'(req_n), 32'((v.kind == 0) ? v.lat : (v.kind == 1) ? 0 : TO));
        if (v.kind != 1) begin
            chk({tag, "_dm_addr"}, a0, {v.addr[31:2], 2'b00});
            chk({tag, "_dm_be"}, 32'(b0), 32'(v.be));
            chk({tag, "_dm_we"}, 32'(we0), 32'(v.wr != 2'd0));
            chk({tag, "_dm_wdata"}, wd0, v.dwd);
            chk({tag, "_dm_stable"}, 32'(unstable), 32'd0);
        end
        if (v.kind == 0 && v.wr == 2'd0) rd_model = v.res;
        chk({tag, "_rdata"}, rdata_o, rd_model);
        if (v.kind != 0) chk({tag, "_fault_addr"}, fault_addr_o, v.addr);
    endtask

    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        int np;
        np = int'(done_o) + int'(misalign_o) + int'(buserr_o);
        if (!rst && (np > 1 || (np > 0 && prev_pulse))) viol++;
        prev_pulse = np > 0;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    vec_t tbl[13];
    vec_t rv;

    initial begin
        tbl[0]  = mk(3'd1, 2'd0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0, 4'hF, 32'h0, 32'hDEADBEEF);
        tbl[1]  = mk(3'd4, 2'd0, 32'h103, 32'h0, 1, 32'h80112233, 0, 4'h8, 32'h0, 32'hFFFFFF80);
        tbl[2]  = mk(3'd5, 2'd0, 32'h103, 32'h0, 1, 32'h80112233, 0, 4'h8, 32'h0, 32'h00000080);
        tbl[3]  = mk(3'd2, 2'd0, 32'h102, 32'h0, 1, 32'h80112233, 0, 4'hC, 32'h0, 32'hFFFF8011);
        tbl[4]  = mk(3'd3, 2'd0, 32'h102, 32'h0, 2, 32'h80112233, 0, 4'hC, 32'h0, 32'h00008011);
        tbl[5]  = mk(3'd4, 2'd0, 32'h100, 32'h0, 1, 32'h80112233, 0, 4'h1, 32'h0, 32'h00000033);
        tbl[6]  = mk(3'd0, 2'd3, 32'h201, 32'hA5, 2, 32'h0, 0, 4'h2, 32'hA5A5A5A5, 32'h0);
        tbl[7]  = mk(3'd0, 2'd2, 32'h203, 32'h1234, 1, 32'h0, 1, 4'h0, 32'h0, 32'h0);
        tbl[8]  = mk(3'd1, 2'd0, 32'h204, 32'h0, 1, 32'h12345678, 0, 4'hF, 32'h0, 32'h12345678);
        tbl[9]  = mk(3'd1, 2'd0, 32'h300, 32'h0, 0, 32'h0, 2, 4'hF, 32'h0, 32'h0);
        tbl[10] = mk(3'd1, 2'd2, 32'h202, 32'h1234ABCD, 1, 32'h55555555, 0, 4'hC, 32'hABCDABCD, 32'h0);
        tbl[11] = mk(3'd0, 2'd1, 32'h3FC, 32'hCAFEF00D, TO, 32'h0, 0, 4'hF, 32'hCAFEF00D, 32'h0);
        tbl[12] = mk(3'd2, 2'd0, 32'h101, 32'h0, 1, 32'h0, 1, 4'h0, 32'h0, 32'h0);

        rst = 1'b1; MEM_valid = 1'b0; MEM_MemRead = 3'd0; MEM_MemWrite = 2'd0;
        MEM_addr = 32'h0; MEM_wdata = 32'h0; dm_ack = 1'b0; dm_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", 32'(stall_o), 32'd0);
        chk("reset_pulses", {29'b0, done_o, misalign_o, buserr_o}, 32'd0);
        chk("reset_rdata", rdata_o, 32'h0);
        chk("reset_fault_addr", fault_addr_o, 32'h0);
        chk("reset_dm_ctrl", {26'b0, dm_req_o, dm_we_o, dm_be_o}, 32'h0);
        chk("reset_dm_addr", dm_addr_o, 32'h0);
        chk("reset_dm_wdata", dm_wdata_o, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Flushed instruction with a load code, plus a stray ack: nothing may happen.
        MEM_valid = 1'b0; MEM_MemRead = 3'd1; MEM_addr = 32'h40; dm_ack = 1'b1;
        #1;
        chk("flushed_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        dm_ack = 1'b0;
        #1;
        chk("flushed_req", 32'(dm_req_o), 32'd0);
        chk("stray_ack_done", 32'(done_o), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset during the 2nd BUS cycle, then a late ack.
        MEM_valid = 1'b1; MEM_MemRead = 3'd1; MEM_MemWrite = 2'd0; MEM_addr = 32'h500;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1;
        chk("rstbus_req_before", 32'(dm_req_o), 32'd1);
        rst = 1'b1; MEM_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; dm_ack = 1'b1; dm_rdata = 32'hFFFFFFFF;
        #1;
        chk("rstbus_req_after", 32'(dm_req_o), 32'd0);
        chk("rstbus_stall_after", 32'(stall_o), 32'd0);
        rd_model = 32'h0;
        chk("rstbus_rdata_cleared", rdata_o, rd_model);
        @(posedge clk); #1;
        dm_ack = 1'b0;
        #1;
        chk("late_ack_done", 32'(done_o), 32'd0);
        chk("late_ack_rdata", rdata_o, rd_model);
        chk("late_ack_req", 32'(dm_req_o), 32'd0);
        @(posedge clk); #1;
        run_vec(mk(3'd0, 2'd1, 32'h600, 32'h0BADF00D, 1, 32'h0, 0, 4'hF, 32'h0BADF00D, 32'h0), "post_rst_sw");

        for (int i = 0; i < 150; i++) begin
            rv.rd = 3'($urandom_range(0, 5));
            rv.wr = 2'($urandom_range(0, 3));
            if (rv.rd == 3'd0 && rv.wr == 2'd0) rv.rd = 3'd1;
            rv.addr = $urandom;
            if ($urandom_range(0, 1) == 0) rv.addr[1:0] = 2'b00;
            rv.wdata = $urandom;
            rv.rword = $urandom;
            rv.lat = $urandom_range(0, 11);
            rv.kind = 0; rv.be = 4'h0; rv.dwd = 32'h0; rv.res = 32'h0;
            run_vec(model(rv), $sformatf("rand%0d", i));
        end

        MEM_valid = 1'b0;
        repeat (2) @(posedge clk);
        chk("pulse_exclusive", 32'(viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
